// File: rtl/hptdc_jtag_target.sv
// HPTDC-side IEEE 1149.1 TAP responder: oversampled TCK/TMS/TDI/TRSTn, a 16-state TAP,
// and IDCODE / BYPASS / CONTROL / STATUS data registers.
module hptdc_jtag_target #(
    parameter int                     IR_LENGTH   = 5,
    parameter logic [31:0]            ID_CODE     = 32'h8470_DACE,
    parameter int                     CTRL_LENGTH = 40,
    parameter int                     STAT_LENGTH = 62,
    parameter logic [CTRL_LENGTH-1:0] CTRL_RESET  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tck_i,
    input  logic                   tms_i,
    input  logic                   tdi_i,
    input  logic                   trstn_i,
    output logic                   tdo_o,
    output logic                   tdo_oe_o,
    output logic [IR_LENGTH-1:0]   ir_o,
    output logic [CTRL_LENGTH-1:0] control_o,
    output logic                   control_upd_o,
    input  logic [STAT_LENGTH-1:0] status_i,
    output logic [3:0]             tap_state_o
);

    localparam int DR_W = (STAT_LENGTH > CTRL_LENGTH) ? ((STAT_LENGTH > 32) ? STAT_LENGTH : 32)
                                                      : ((CTRL_LENGTH > 32) ? CTRL_LENGTH : 32);

    localparam logic [IR_LENGTH-1:0] IR_IDCODE  = IR_LENGTH'(5'h01);
    localparam logic [IR_LENGTH-1:0] IR_CONTROL = IR_LENGTH'(5'h09);
    localparam logic [IR_LENGTH-1:0] IR_STATUS  = IR_LENGTH'(5'h0A);

    // One-hot marker of the bit where TDI enters for each selectable register.
    localparam logic [DR_W-1:0] MSB_ID   = DR_W'(1) << 31;
    localparam logic [DR_W-1:0] MSB_CTRL = DR_W'(1) << (CTRL_LENGTH - 1);
    localparam logic [DR_W-1:0] MSB_STAT = DR_W'(1) << (STAT_LENGTH - 1);
    localparam logic [DR_W-1:0] MSB_BYP  = DR_W'(1);

    typedef enum logic [3:0] {
        TLR     = 4'hF, RTI     = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
        SH_DR   = 4'h2, EX1_DR  = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
        UPD_DR  = 4'h5, SEL_IR  = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
        EX1_IR  = 4'h9, PAU_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    tap_state_e state_q, state_d;

    // Synchroniser vector order: {trstn, tdi, tms, tck}
    logic [3:0] sync1_q, sync2_q;
    logic       tck_prev_q;
    logic       tck_s, tms_s, tdi_s, trst_active;
    logic       tck_rise, tck_fall;

    logic [IR_LENGTH-1:0]   ir_q, ir_d, ir_shift_q, ir_shift_d;
    logic [DR_W-1:0]        dr_shift_q, dr_shift_d;
    logic [CTRL_LENGTH-1:0] control_q, control_d;
    logic                   control_upd_q, control_upd_d;
    logic                   tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;

    logic [DR_W-1:0] capture_val, dr_msb, dr_shifted;
    logic            in_shift_dr, in_shift_ir;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            sync1_q    <= {trstn_i, tdi_i, tms_i, tck_i};
            sync2_q    <= sync1_q;
            tck_prev_q <= sync2_q[0];
        end
    end

    assign tck_s       = sync2_q[0];
    assign tms_s       = sync2_q[1];
    assign tdi_s       = sync2_q[2];
    assign trst_active = ~sync2_q[3];
    assign tck_rise    = tck_s & ~tck_prev_q;
    assign tck_fall    = ~tck_s & tck_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (trst_active) begin
            state_d = TLR;
        end else if (tck_rise) begin
            unique case (state_q)
                TLR:    state_d = tms_s ? TLR    : RTI;
                RTI:    state_d = tms_s ? SEL_DR : RTI;
                SEL_DR: state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR: state_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:  state_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR: state_d = tms_s ? UPD_DR : PAU_DR;
                PAU_DR: state_d = tms_s ? EX2_DR : PAU_DR;
                EX2_DR: state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR: state_d = tms_s ? SEL_DR : RTI;
                SEL_IR: state_d = tms_s ? TLR    : CAP_IR;
                CAP_IR: state_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:  state_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR: state_d = tms_s ? UPD_IR : PAU_IR;
                PAU_IR: state_d = tms_s ? EX2_IR : PAU_IR;
                EX2_IR: state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR: state_d = tms_s ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    always_comb begin
        tap_state_o = state_q;
        in_shift_dr = (state_q == SH_DR);
        in_shift_ir = (state_q == SH_IR);
    end

    // Unknown instructions fall through to BYPASS: one bit, captures zero.
    always_comb begin
        capture_val = '0;
        dr_msb      = MSB_BYP;
        unique case (ir_q)
            IR_IDCODE: begin
                capture_val = DR_W'(ID_CODE);
                dr_msb      = MSB_ID;
            end
            IR_CONTROL: begin
                capture_val = DR_W'(control_q);
                dr_msb      = MSB_CTRL;
            end
            IR_STATUS: begin
                capture_val = DR_W'(status_i);
                dr_msb      = MSB_STAT;
            end
            default: ;
        endcase
        dr_shifted = ((dr_shift_q >> 1) & ~dr_msb) | ({DR_W{tdi_s}} & dr_msb);
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        ir_d          = ir_q;
        ir_shift_d    = ir_shift_q;
        dr_shift_d    = dr_shift_q;
        control_d     = control_q;
        control_upd_d = 1'b0;
        tdo_d         = tdo_q;
        tdo_oe_d      = tdo_oe_q;
        if (trst_active) begin
            ir_d       = IR_IDCODE;
            ir_shift_d = '0;
            dr_shift_d = '0;
            tdo_oe_d   = 1'b0;
        end else if (tck_rise) begin
            case (state_q)
                CAP_IR: ir_shift_d = IR_LENGTH'(2'b01);
                SH_IR:  ir_shift_d = {tdi_s, ir_shift_q[IR_LENGTH-1:1]};
                UPD_IR: ir_d       = ir_shift_q;
                CAP_DR: dr_shift_d = capture_val;
                SH_DR:  dr_shift_d = dr_shifted;
                UPD_DR: begin
                    if (ir_q == IR_CONTROL) begin
                        control_d     = dr_shift_q[CTRL_LENGTH-1:0];
                        control_upd_d = 1'b1;
                    end
                end
                default: ;
            endcase
            if (state_d == TLR) begin
                ir_d = IR_IDCODE;
            end
        end else if (tck_fall) begin
            tdo_oe_d = in_shift_dr | in_shift_ir;
            if (in_shift_ir) begin
                tdo_d = ir_shift_q[0];
            end else if (in_shift_dr) begin
                tdo_d = dr_shift_q[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q          <= IR_IDCODE;
            ir_shift_q    <= '0;
            dr_shift_q    <= '0;
            control_q     <= CTRL_RESET;
            control_upd_q <= 1'b0;
            tdo_q         <= 1'b0;
            tdo_oe_q      <= 1'b0;
        end else begin
            ir_q          <= ir_d;
            ir_shift_q    <= ir_shift_d;
            dr_shift_q    <= dr_shift_d;
            control_q     <= control_d;
            control_upd_q <= control_upd_d;
            tdo_q         <= tdo_d;
            tdo_oe_q      <= tdo_oe_d;
        end
    end

    assign ir_o          = ir_q;
    assign control_o     = control_q;
    assign control_upd_o = control_upd_q;
    assign tdo_o         = tdo_q;
    assign tdo_oe_o      = tdo_oe_q;

endmodule

// File: tb/tb_hptdc_jtag_target.sv
// Directed bench for hptdc_jtag_target: drives TCK at 5 clk per phase and checks
// IDCODE, BYPASS, CONTROL, STATUS, TMS reset, TRSTn and rst behaviour.
module tb_hptdc_jtag_target;

    logic        clk = 1'b0;
    logic        rst;
    logic        tck_i, tms_i, tdi_i, trstn_i;
    logic        tdo_o, tdo_oe_o;
    logic [4:0]  ir_o;
    logic [39:0] control_o;
    logic        control_upd_o;
    logic [61:0] status_i;
    logic [3:0]  tap_state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cycles = 0;

    always #5 clk = ~clk;

    hptdc_jtag_target dut (
        .clk           (clk),
        .rst           (rst),
        .tck_i         (tck_i),
        .tms_i         (tms_i),
        .tdi_i         (tdi_i),
        .trstn_i       (trstn_i),
        .tdo_o         (tdo_o),
        .tdo_oe_o      (tdo_oe_o),
        .ir_o          (ir_o),
        .control_o     (control_o),
        .control_upd_o (control_upd_o),
        .status_i      (status_i),
        .tap_state_o   (tap_state_o)
    );

    // Total clk cycles with control_upd_o high; a single-clk pulse adds exactly 1.
    always @(posedge clk) begin
        if (control_upd_o) upd_cycles <= upd_cycles + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo, output logic oe);
        tms_i = tms;
        tdi_i = tdi;
        repeat (5) @(posedge clk);
        #1;
        tdo = tdo_o;
        oe  = tdo_oe_o;
        tck_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tck_i = 1'b0;
    endtask

    task automatic tms_step(input logic tms);
        logic d, o;
        tck_cycle(tms, 1'b0, d, o);
    endtask

    // From RTI: load an instruction and return to RTI (update on the UpdIR rise).
    task automatic shift_ir(input logic [4:0] code);
        logic d, o;
        tms_step(1'b1);
        tms_step(1'b1);
        tms_step(1'b0);
        tms_step(1'b0);
        for (int i = 0; i < 5; i++) tck_cycle(i == 4, code[i], d, o);
        tms_step(1'b1);
        tms_step(1'b0);
    endtask

    // From RTI: capture, shift len bits LSB first, update, return to RTI.
    task automatic shift_dr(input int len, input logic [63:0] din,
                            output logic [63:0] dout, output int oe_cnt);
        logic d, o;
        dout   = '0;
        oe_cnt = 0;
        tck_cycle(1'b1, 1'b0, d, o); oe_cnt += int'(o);
        tck_cycle(1'b0, 1'b0, d, o); oe_cnt += int'(o);
        tck_cycle(1'b0, 1'b0, d, o); oe_cnt += int'(o);
        for (int i = 0; i < len; i++) begin
            tck_cycle(i == len - 1, din[i], d, o);
            dout[i] = d;
            oe_cnt += int'(o);
        end
        tck_cycle(1'b1, 1'b0, d, o); oe_cnt += int'(o);
        tck_cycle(1'b0, 1'b0, d, o); oe_cnt += int'(o);
    endtask

    initial begin
        logic [63:0] dout;
        int          oe_cnt;
        int          upd0;
        logic        d, o;

        rst = 1'b1; tck_i = 1'b0; tms_i = 1'b0; tdi_i = 1'b0; trstn_i = 1'b1;
        status_i = 62'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", tap_state_o, 4'hF);
        check("rst_ir", ir_o, 5'h01);
        check("rst_control", control_o, 40'h0);
        check("rst_tdo", {tdo_oe_o, tdo_o, control_upd_o}, 3'b000);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // IDCODE read straight out of reset
        tms_step(1'b0);
        check("rti_state", tap_state_o, 4'hC);
        shift_dr(32, 64'h0, dout, oe_cnt);
        check("idcode_tdo", dout, 64'h8470_DACE);
        check("idcode_oe_cnt", oe_cnt, 32);
        check("idcode_end_state", tap_state_o, 4'hC);

        // BYPASS: TDO is TDI delayed one TCK, first bit zero
        shift_ir(5'h1F);
        check("bypass_ir", ir_o, 5'h1F);
        shift_dr(8, 64'hA5, dout, oe_cnt);
        check("bypass_tdo", dout, 64'h4A);
        check("bypass_ctrl", control_o, 40'h0);

        // CONTROL write, then write-while-reading
        shift_ir(5'h09);
        check("ctrl_ir", ir_o, 5'h09);
        upd0 = upd_cycles;
        shift_dr(40, 64'h12_3456_789A, dout, oe_cnt);
        check("ctrl_first_tdo", dout, 64'h0);
        check("ctrl_value", control_o, 40'h12_3456_789A);
        check("ctrl_upd_width", upd_cycles - upd0, 1);
        upd0 = upd_cycles;
        shift_dr(40, 64'hA5_A50F_0F33, dout, oe_cnt);
        check("ctrl_readback", dout, 64'h12_3456_789A);
        check("ctrl_value2", control_o, 40'hA5_A50F_0F33);
        check("ctrl_upd_width2", upd_cycles - upd0, 1);

        // STATUS capture, no update strobe
        status_i = 62'h2AAA_AAAA_AAAA_AAAA;
        shift_ir(5'h0A);
        upd0 = upd_cycles;
        shift_dr(62, 64'h0, dout, oe_cnt);
        check("status_tdo", dout, 64'h2AAA_AAAA_AAAA_AAAA);
        check("status_oe_cnt", oe_cnt, 62);
        check("status_no_upd", upd_cycles - upd0, 0);
        check("status_ctrl_kept", control_o, 40'hA5_A50F_0F33);

        // Five TMS=1 rises from Shift-DR reach Test-Logic-Reset
        tms_step(1'b1);
        tms_step(1'b0);
        tms_step(1'b0);
        check("shdr_state", tap_state_o, 4'h2);
        for (int i = 0; i < 5; i++) tms_step(1'b1);
        check("tms_reset_state", tap_state_o, 4'hF);
        check("tms_reset_ir", ir_o, 5'h01);

        // TRSTn mid Shift-IR
        tms_step(1'b0);
        shift_ir(5'h09);
        tms_step(1'b1);
        tms_step(1'b1);
        tms_step(1'b0);
        tms_step(1'b0);
        tck_cycle(1'b0, 1'b1, d, o);
        tck_cycle(1'b0, 1'b1, d, o);
        check("shir_state", tap_state_o, 4'hA);
        check("shir_oe", tdo_oe_o, 1'b1);
        trstn_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("trst_state", tap_state_o, 4'hF);
        check("trst_ir", ir_o, 5'h01);
        check("trst_oe", tdo_oe_o, 1'b0);
        check("trst_ctrl_kept", control_o, 40'hA5_A50F_0F33);
        trstn_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // rst mid CONTROL shift, then a clean CONTROL write
        tms_step(1'b0);
        shift_ir(5'h09);
        tms_step(1'b1);
        tms_step(1'b0);
        tms_step(1'b0);
        for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1, d, o);
        rst = 1'b1;
        #1;
        check("midrst_state", tap_state_o, 4'hF);
        check("midrst_ir", ir_o, 5'h01);
        check("midrst_control", control_o, 40'h0);
        check("midrst_outs", {tdo_oe_o, tdo_o, control_upd_o}, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tms_step(1'b0);
        shift_ir(5'h09);
        upd0 = upd_cycles;
        shift_dr(40, 64'hC0_FFEE_1234, dout, oe_cnt);
        check("post_rst_tdo", dout, 64'h0);
        check("post_rst_ctrl", control_o, 40'hC0_FFEE_1234);
        check("post_rst_upd", upd_cycles - upd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hptdc_jtag_target.md
Name: hptdc_jtag_target

Overview:
- IEEE 1149.1 TAP responder that models the HPTDC end of the JTAG link, used as on-board loopback and bench target for the JTAG master.
- Oversamples the incoming TCK/TMS/TDI/TRSTn with the system clock and runs a full 16-state TAP controller.
- Implements IR, IDCODE, BYPASS, CONTROL (write/read) and STATUS (read) registers, and exposes CONTROL contents and update strobes to fabric logic.

Parameters:
- IR_LENGTH, 5, instruction register width
- ID_CODE, 32'h8470_DACE, value captured by IDCODE
- CTRL_LENGTH, 40, CONTROL data register width
- STAT_LENGTH, 62, STATUS data register width
- CTRL_RESET, 40'h0, CONTROL value after rst

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- tck_i  input  1  JTAG test clock from master, asynchronous to clk
- tms_i  input  1  JTAG test mode select
- tdi_i  input  1  serial data from master
- trstn_i  input  1  JTAG reset, active low
- tdo_o  output  1  serial data to master
- tdo_oe_o  output  1  high while in Shift-DR or Shift-IR
- ir_o  output  IR_LENGTH  current (updated) instruction
- control_o  output  CTRL_LENGTH  last CONTROL value written via Update-DR
- control_upd_o  output  1  one-clk pulse when control_o changes
- status_i  input  STAT_LENGTH  value captured in Capture-DR under STATUS
- tap_state_o  output  4  current TAP state

Behaviour:
- Reset (rst=1, async): TAP state Test-Logic-Reset (4'hF), ir_o=5'h01 (IDCODE), control_o=CTRL_RESET, tdo_o=0, tdo_oe_o=0, control_upd_o=0, shift registers 0, synchroniser flops 0.
- Input sync: tck_i, tms_i, tdi_i, trstn_i each pass a 2-flop synchroniser. A TCK rise or fall is detected on the clk after the synchronised value changes. Edge latency from pin is 3 clk max.
- Timing: TCK high and low phases must each be at least 4 clk periods. Faster TCK is out of range and behaviour is undefined.
- TCK rise: sample synchronised TMS/TDI and perform the shift/capture action of the current state. The state then advances per the standard 1149.1 graph.
- State encoding: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- TCK fall: tdo_o <= LSB of the active shift register. tdo_oe_o=1 only in ShDR or ShIR; otherwise tdo_oe_o=0 and tdo_o holds its last value.
- TRSTn: synchronised trstn low forces TLR on the next clk, regardless of TCK, and holds while low. ir_o returns to IDCODE; control_o is NOT cleared.
- TLR entry (any path, including 5 TCK rises with TMS=1): ir_o <= 5'h01.
- CapIR: ir_shift <= {0…0,2'b01}.
- ShIR: ir_shift <= {tdi, ir_shift[IR_LENGTH-1:1]}, LSB first.
- UpdIR: ir_o <= ir_shift.
- Instruction decode (unknown codes select BYPASS):
  - 5'h01 IDCODE: 32 bits, captures ID_CODE.
  - 5'h09 CONTROL: CTRL_LENGTH bits, captures control_o.
  - 5'h0A STATUS: STAT_LENGTH bits, captures status_i.
  - 5'h1F BYPASS: 1 bit, captures 0.
- CapDR: load the selected register into dr_shift (max width 62, upper bits zero).
- ShDR: dr_shift shifts right. TDI enters at bit (len-1) of the selected register, so TDO delay equals register length.
- UpdDR: under CONTROL only, control_o <= dr_shift[CTRL_LENGTH-1:0] and control_upd_o pulses high for exactly 1 clk. Update under any other instruction has no effect.
- Pause states: hold all shift registers.
- Simultaneous events: rst overrides everything. TRSTn overrides a coincident TCK edge.
- rst or TRSTn mid-shift: partial shift data is discarded and control_o is unchanged (TRSTn case).

Test Plan:
- After rst, clock TMS 0,1,0,0 then 32 ShDR bits (TMS=1 on last) -> TDO serial LSB-first = ID_CODE 0x8470DACE; tdo_oe_o high for exactly those 32 TCK periods.
- Load IR 5'h1F, shift 8'hA5 through DR -> TDO equals TDI delayed 1 TCK (first bit 0), control_o unchanged.
- Load IR 5'h09, shift 40'h12_3456_789A, pass UpdDR -> control_o=40'h123456789A, control_upd_o one clk wide. Repeat a shift -> TDO returns 40'h123456789A.
- status_i=62'h2AAA_AAAA_AAAA_AAAA, IR 5'h0A, shift 62 bits -> TDO returns that value; control_upd_o stays 0 at UpdDR.
- From ShDR clock 5 TCK with TMS=1 -> tap_state_o=4'hF, ir_o=5'h01. Separately, pull trstn_i low mid-ShIR -> TLR within 3 clk.
- Assert rst mid-CONTROL shift -> all outputs return to reset values immediately; the next full CONTROL write completes correctly.
